vertex_fetch: RTL
=================

# vertex_fetch

Sequential reader for the model ROM. On a start pulse it walks the ROM from address 0 and fetches one 32-bit word per cycle. Every nine consecutive words (x0,y0,z0,x1,y1,z1,x2,y2,z2) are assembled into one triangle, which is presented downstream to the transform/raster stage over a valid/ready handshake. It sits between the combinational model ROM and the first geometry pipeline stage.

## Interface
- addr_width, 8: ROM address width; num_triangles*9 must be ≤ 2^addr_width.
- data_width, 32: ROM word and vertex coordinate width.
- num_triangles, 2: triangles in the model; must be ≥ 1.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a model pass; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until the return to IDLE.
- done  out  1  one-cycle pulse after the last triangle handshake.
- rom_addr  out  addr_width  ROM read address (combinational ROM; data valid in the same cycle).
- rom_data  in  data_width  ROM read data.
- tri_valid  out  1  assembled triangle available.
- tri_ready  in  1  downstream accepts the triangle.
- tri_index  out  8  index of the presented triangle, starting at 0.
- tri_x0, tri_y0, tri_z0, tri_x1, tri_y1, tri_z1, tri_x2, tri_y2, tri_z2  out  data_width each  triangle vertex coordinates.

## Operation
- States: IDLE, FETCH, PRESENT, DONE.
- IDLE, start=1: go to FETCH. Word counter w=0, addr counter a=0, triangle counter t=0.
- IDLE, start=0: stay in IDLE.
- FETCH:
  - rom_addr=a.
  - On each edge, capture rom_data into coordinate register w, in the order x0,y0,z0,x1,y1,z1,x2,y2,z2.
  - Then a←a+1 and w←w+1.
  - When w=8 is captured: w←0, go to PRESENT.
- PRESENT:
  - tri_valid=1. The coordinate registers and tri_index=t are held stable while tri_ready=0.
  - On an edge with tri_valid&tri_ready: if t=num_triangles-1, go to DONE; else t←t+1 and go to FETCH.
  - a continues from its current value; it is not recomputed.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- busy=1 in FETCH, PRESENT and DONE.
- start is ignored outside IDLE. start held high through DONE causes a new pass only after IDLE is re-entered.
- rom_addr is 0 in IDLE, PRESENT and DONE. The ROM is only addressed meaningfully in FETCH.
- Arithmetic and width rules:
  - a is addr_width wide and never wraps, given the parameter constraint.
  - t is 8 bits wide; num_triangles ≤ 256.
  - Coordinates pass through unmodified; no sign or width conversion.
- Reset (asynchronous, any state, including mid-fetch or mid-present):
  - State←IDLE; a, w, t←0; all coordinate registers←0.
  - tri_valid, busy, done←0.
  - A partially fetched triangle is discarded and never presented.

## Timing
- Start accepted at edge E0:
  - busy=1 after E0.
  - Words captured at E1..E9.
  - tri_valid=1 after E9 (9-cycle first-triangle latency).
- Handshake at edge H, more triangles remaining:
  - tri_valid=0 after H.
  - Next triangle valid after H+9.
- Handshake at edge H, last triangle:
  - tri_valid=0 and done=1 after H.
  - done=0 and busy=0 after H+1.
- tri_ready=1 held permanently gives a throughput of one triangle per 10 cycles.
- tri_ready may be asserted before tri_valid. It has no effect outside PRESENT.
- Outputs are registered, except rom_addr, which may be decoded from the state and a.

## Test plan
- Reset, then idle: after rst_n rises, all outputs are 0. With start=0 for 20 cycles, busy, tri_valid and done stay 0.
- Full pass with the model ROM, tri_ready=1, start pulsed 1 cycle:
  - Triangle 0 valid 9 cycles after start: (10,20,800),(35,40,660),(30,60,700), tri_index=0.
  - Triangle 1 10 cycles later: (36,41,660),(31,61,700),(45,50,750), tri_index=1.
  - done pulses once, busy then drops.
- Backpressure: hold tri_ready=0 for 15 cycles during triangle 0.
  - tri_valid stays 1 and all nine coordinates and tri_index stay stable.
  - rom_addr=0 throughout.
  - After tri_ready rises, triangle 1 follows 9 cycles later.
- start ignored while busy: pulse start during FETCH and during PRESENT. Exactly 2 triangles and 1 done pulse result.
- Reset mid-operation: drop rst_n on the 5th FETCH cycle of triangle 1.
  - Outputs clear immediately.
  - A new start yields triangle 0 = (10,20,800)… with tri_index=0.
- Back-to-back passes: with start held high continuously, a second pass begins after DONE→IDLE and reproduces identical triangle data.

Source files
------------

// File: rtl/vertex_fetch.sv
// vertex_fetch: walks the model ROM from address 0, packs every nine words into a
// triangle and presents it downstream over a valid/ready handshake.
module vertex_fetch #(
  parameter int addr_width    = 8,
  parameter int data_width    = 32,
  parameter int num_triangles = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] rom_addr,
  input  logic [data_width-1:0] rom_data,
  output logic                  tri_valid,
  input  logic                  tri_ready,
  output logic [7:0]            tri_index,
  output logic [data_width-1:0] tri_x0,
  output logic [data_width-1:0] tri_y0,
  output logic [data_width-1:0] tri_z0,
  output logic [data_width-1:0] tri_x1,
  output logic [data_width-1:0] tri_y1,
  output logic [data_width-1:0] tri_z1,
  output logic [data_width-1:0] tri_x2,
  output logic [data_width-1:0] tri_y2,
  output logic [data_width-1:0] tri_z2
);
  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;
  localparam logic [addr_width-1:0] A_ONE  = 1;
  localparam logic [7:0]            T_LAST = 8'(num_triangles - 1);
  state_t                state_q, state_d;
  logic [addr_width-1:0] a_q, a_d;
  logic [3:0]            w_q, w_d;
  logic [7:0]            t_q, t_d;
  logic [data_width-1:0] coord_q [9];
  logic [data_width-1:0] coord_d [9];
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    w_d     = w_q;
    t_d     = t_q;
    coord_d = coord_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        a_d     = '0;
        w_d     = '0;
        t_d     = '0;
      end
      FETCH: begin
        coord_d[w_q] = rom_data;
        a_d          = a_q + A_ONE;
        w_d          = (w_q == 4'd8) ? 4'd0 : w_q + 4'd1;
        state_d      = (w_q == 4'd8) ? PRESENT : FETCH;
      end
      PRESENT: if (tri_ready) begin
        state_d = (t_q == T_LAST) ? DONE : FETCH;
        t_d     = (t_q == T_LAST) ? t_q : t_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      w_q     <= '0;
      t_q     <= '0;
      coord_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      w_q     <= w_d;
      t_q     <= t_d;
      coord_q <= coord_d;
    end
  end
  // Status outputs are pure decodes of the state flops, so no input reaches them combinationally.
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign tri_valid = state_q == PRESENT;
  assign rom_addr  = (state_q == FETCH) ? a_q : '0;
  assign tri_index = t_q;
  assign tri_x0    = coord_q[0];
  assign tri_y0    = coord_q[1];
  assign tri_z0    = coord_q[2];
  assign tri_x1    = coord_q[3];
  assign tri_y1    = coord_q[4];
  assign tri_z1    = coord_q[5];
  assign tri_x2    = coord_q[6];
  assign tri_y2    = coord_q[7];
  assign tri_z2    = coord_q[8];
endmodule
